// File: rtl/sd_xfer_ctrl.sv
// Round-robin scheduler sharing one HPS SD channel and its sector buffer between
// two emulated drives: arbitration, HPS handshake, sector-length check, watchdog.
module sd_xfer_ctrl #(
  parameter int TIMEOUT_W = 20
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        busy,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_FIN, S_DONE} state_t;

  localparam logic [TIMEOUT_W-1:0] WD_LAST      = TIMEOUT_W'(1);
  localparam logic [9:0]           SECTOR_BYTES = 10'd512;
  localparam logic [9:0]           CNT_MAX      = 10'd1023;

  state_t               state_q, state_d;
  logic                 id_q, id_d;
  logic                 op_wr_q, op_wr_d;
  logic                 last_q, last_d;
  logic                 fail_q, fail_d;
  logic [9:0]           cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [1:0]           done_q, done_d;
  logic [1:0]           err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 sd_rd_q, sd_rd_d;
  logic                 sd_wr_q, sd_wr_d;
  logic [31:0]          sd_lba_q, sd_lba_d;

  logic [1:0]           cand;
  logic                 pick;
  logic                 wd_expire;

  always_comb begin
    cand      = req_rd | req_wr;
    pick      = cand[~last_q] ? ~last_q : last_q;
    // expiry is the cycle the countdown lands on zero
    wd_expire = (wd_q == WD_LAST);

    state_d  = state_q;
    id_d     = id_q;
    op_wr_d  = op_wr_q;
    last_d   = last_q;
    fail_d   = fail_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    err_d    = 2'b00;
    sd_rd_d  = sd_rd_q;
    sd_wr_d  = sd_wr_q;
    sd_lba_d = sd_lba_q;

    case (state_q)
      S_IDLE: begin
        // a lingering ack from a timed-out transfer blocks a new request
        if ((cand != 2'b00) && !sd_ack) begin
          id_d     = pick;
          op_wr_d  = ~req_rd[pick];
          sd_rd_d  = req_rd[pick];
          sd_wr_d  = ~req_rd[pick];
          sd_lba_d = pick ? req_lba1 : req_lba0;
          gnt_d    = pick ? 2'b10 : 2'b01;
          fail_d   = 1'b0;
          wd_d     = '1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        wd_d = wd_q - WD_LAST;
        if (sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          cnt_d   = '0;
          wd_d    = '1;
          state_d = S_XFER;
        end else if (wd_expire) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          fail_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_XFER: begin
        wd_d = wd_q - WD_LAST;
        if (!op_wr_q && sd_buff_wr && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 10'd1;
        end
        if (!sd_ack) begin
          fail_d  = !op_wr_q && (cnt_q != SECTOR_BYTES);
          state_d = S_FIN;
        end else if (wd_expire) begin
          fail_d  = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d[id_q] = ~fail_q;
        err_d[id_q]  = fail_q;
        last_d       = id_q;
        state_d      = S_DONE;
      end
      S_DONE: begin
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      id_q     <= 1'b0;
      op_wr_q  <= 1'b0;
      last_q   <= 1'b1;
      fail_q   <= 1'b0;
      cnt_q    <= '0;
      wd_q     <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      busy_q   <= 1'b0;
      sd_rd_q  <= 1'b0;
      sd_wr_q  <= 1'b0;
      sd_lba_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      op_wr_q  <= op_wr_d;
      last_q   <= last_d;
      fail_q   <= fail_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      sd_rd_q  <= sd_rd_d;
      sd_wr_q  <= sd_wr_d;
      sd_lba_q <= sd_lba_d;
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = busy_q;
  assign sd_lba = sd_lba_q;
  assign sd_rd  = sd_rd_q;
  assign sd_wr  = sd_wr_q;

endmodule

// File: tb/tb_sd_xfer_ctrl.sv
// Self-checking bench for sd_xfer_ctrl: vector table, randomized rounds against a
// round-robin reference model, reset abort, and a short-watchdog instance.
module tb_sd_xfer_ctrl;

  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  // main instance (default watchdog)
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_lba0, req_lba1;
  logic [1:0]  gnt, done, err;
  logic        busy, sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [31:0] sd_lba;

  // short-watchdog instance
  logic [1:0]  t_req_rd, t_req_wr;
  logic [31:0] t_req_lba0, t_req_lba1;
  logic [1:0]  t_gnt, t_done, t_err;
  logic        t_busy, t_sd_rd, t_sd_wr, t_sd_ack, t_sd_buff_wr;
  logic [31:0] t_sd_lba;

  sd_xfer_ctrl u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_rd(req_rd), .req_wr(req_wr), .req_lba0(req_lba0), .req_lba1(req_lba1),
    .gnt(gnt), .done(done), .err(err), .busy(busy),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr)
  );

  sd_xfer_ctrl #(.TIMEOUT_W(4)) u_dut_to (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .req_rd(t_req_rd), .req_wr(t_req_wr), .req_lba0(t_req_lba0), .req_lba1(t_req_lba1),
    .gnt(t_gnt), .done(t_done), .err(t_err), .busy(t_busy),
    .sd_lba(t_sd_lba), .sd_rd(t_sd_rd), .sd_wr(t_sd_wr),
    .sd_ack(t_sd_ack), .sd_buff_wr(t_sd_buff_wr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_checks++;
    if (val < lo || val > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
    end
  endtask

  // observations of one transaction, filled by serve()
  logic        obs_found, obs_rd, obs_wr, obs_hold, obs_drop, obs_pre, obs_post, obs_busy_after;
  logic [1:0]  obs_gnt, obs_done, obs_err, obs_gnt_after;
  logic [31:0] obs_lba;
  logic [1:0]  nxt_rd, nxt_wr;

  // HPS side of one transfer; drive requests switch to nxt_* when done/err shows
  task automatic serve(input int ack_dly, input int nstr);
    obs_found = 1'b0;
    for (int i = 0; i < 40 && !obs_found; i++) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr) obs_found = 1'b1;
    end
    obs_gnt = gnt; obs_lba = sd_lba; obs_rd = sd_rd; obs_wr = sd_wr;
    repeat (ack_dly) @(negedge clk_sys);
    obs_hold = sd_rd | sd_wr;
    sd_ack = 1'b1;
    @(negedge clk_sys);
    obs_drop = sd_rd | sd_wr;
    for (int i = 0; i < nstr; i++) begin
      sd_buff_wr = 1'b1;
      @(negedge clk_sys);
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    @(negedge clk_sys);
    obs_pre = |(done | err);
    @(negedge clk_sys);
    obs_done = done; obs_err = err;
    req_rd = nxt_rd; req_wr = nxt_wr;
    @(negedge clk_sys);
    obs_post = |(done | err);
    obs_gnt_after = gnt;
    obs_busy_after = busy;
  endtask

  task automatic check_txn(input string tag, input logic exp_id, input logic exp_wr,
                           input logic exp_err, input logic [31:0] exp_lba);
    logic [1:0] oh;
    oh = exp_id ? 2'b10 : 2'b01;
    check($sformatf("%s_grant_seen", tag), 64'(obs_found), 64'(1));
    check($sformatf("%s_gnt", tag), 64'(obs_gnt), 64'(oh));
    check($sformatf("%s_lba", tag), 64'(obs_lba), 64'(exp_lba));
    check($sformatf("%s_op", tag), 64'({obs_rd, obs_wr}), 64'(exp_wr ? 2'b01 : 2'b10));
    check($sformatf("%s_req_held", tag), 64'(obs_hold), 64'(1));
    check($sformatf("%s_req_drop", tag), 64'(obs_drop), 64'(0));
    check($sformatf("%s_pulse_early", tag), 64'(obs_pre), 64'(0));
    check($sformatf("%s_done", tag), 64'(obs_done), 64'(exp_err ? 2'b00 : oh));
    check($sformatf("%s_err", tag), 64'(obs_err), 64'(exp_err ? oh : 2'b00));
    check($sformatf("%s_pulse_len", tag), 64'(obs_post), 64'(0));
    check($sformatf("%s_gnt_clear", tag), 64'(obs_gnt_after), 64'(0));
    check($sformatf("%s_busy_clear", tag), 64'(obs_busy_after), 64'(0));
    $display("txn %s: drive %0d %s lba=%08h done=%b err=%b", tag, obs_gnt[1],
             obs_wr ? "wr" : "rd", obs_lba, obs_done, obs_err);
  endtask

  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] lba0, lba1;
    int          ack_dly, nstr;
    logic [1:0]  nrd, nwr;
    logic        exp_id, exp_wr, exp_err;
  } vec_t;
  vec_t vecs [12];

  // reference model state for randomized rounds
  int last_m;

  task automatic new_req(input int d);
    int k;
    k = $urandom_range(0, 2);
    if (d == 0) req_lba0 = $urandom; else req_lba1 = $urandom;
    req_rd[d] = (k != 1);
    req_wr[d] = (k != 0);
  endtask

  task automatic random_round(input int r);
    int w, nstr, d, sel, eff;
    logic exp_wr, exp_err;
    logic [31:0] exp_lba;
    for (d = 0; d < 2; d++)
      if (!(req_rd[d] | req_wr[d]) && $urandom_range(0, 1) == 1) new_req(d);
    if ((req_rd | req_wr) == 2'b00) new_req(int'($urandom_range(0, 1)));
    // winner is the first requesting drive after the last one served
    w = -1;
    for (int k = 1; k <= 2; k++) begin
      d = (last_m + k) % 2;
      if (w < 0 && (req_rd[d] | req_wr[d])) w = d;
    end
    exp_wr  = !req_rd[w];
    exp_lba = (w == 1) ? req_lba1 : req_lba0;
    sel = $urandom_range(0, 4);
    nstr = (sel == 0) ? 512 : (sel == 1) ? 511 : (sel == 2) ? 513 :
           (sel == 3) ? 512 : int'($urandom_range(0, 600));
    if (exp_wr) nstr = $urandom_range(0, 3);
    eff = (nstr > 1023) ? 1023 : nstr;
    exp_err = !exp_wr && (eff != 512);
    nxt_rd = req_rd; nxt_wr = req_wr;
    if (exp_wr) nxt_wr[w] = 1'b0; else nxt_rd[w] = 1'b0;
    if (r == 29) begin nxt_rd = 2'b00; nxt_wr = 2'b00; end
    serve(int'($urandom_range(0, 4)), nstr);
    check_txn($sformatf("rnd%0d", r), w[0], exp_wr, exp_err, exp_lba);
    last_m = w;
  endtask

  int rd_drop, err_at;
  logic seen, pulse, found;
  logic [1:0] err_val, done_val;

  initial begin
    reset_n = 1'b0;
    req_rd = 0; req_wr = 0; req_lba0 = 0; req_lba1 = 0; sd_ack = 0; sd_buff_wr = 0;
    t_req_rd = 0; t_req_wr = 0; t_req_lba0 = 0; t_req_lba1 = 0; t_sd_ack = 0; t_sd_buff_wr = 0;
    nxt_rd = 0; nxt_wr = 0;

    //          rd     wr     lba0          lba1          dly nstr  nrd    nwr    id    wr    err
    vecs[0]  = '{2'b01, 2'b00, 32'h0000_1234, 32'h0,        3, 512,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b10, 2'b00, 32'h0,        32'hABCD_0001, 1, 512,  2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 2'b00, 32'h0000_0100, 32'h0000_0200, 0, 512, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 2'b00, 32'h0000_0101, 32'h0000_0200, 2, 512, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'b01, 2'b00, 32'h0000_0055, 32'h0,        2, 511,  2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{2'b00, 2'b01, 32'h0000_0066, 32'h0,        1, 0,    2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{2'b01, 2'b00, 32'h0000_0077, 32'h0,        0, 513,  2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{2'b10, 2'b10, 32'h0,        32'h0000_0888, 2, 512,  2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 2'b10, 32'h0,        32'h0000_0888, 1, 0,    2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{2'b00, 2'b11, 32'h0000_0A00, 32'h0000_0B00, 1, 0,   2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{2'b10, 2'b00, 32'h0,        32'h0000_0C00, 1, 1100, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{2'b01, 2'b10, 32'h0000_0D00, 32'h0000_0E00, 2, 512, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk_sys);
    check("reset_outputs", 64'({gnt, done, err, busy, sd_rd, sd_wr, sd_lba}), 64'(0));
    check("reset_outputs_to", 64'({t_gnt, t_done, t_err, t_busy, t_sd_rd, t_sd_wr, t_sd_lba}), 64'(0));
    reset_n = 1'b1;
    @(negedge clk_sys);

    for (int v = 0; v < 12; v++) begin
      req_rd = vecs[v].rd; req_wr = vecs[v].wr;
      req_lba0 = vecs[v].lba0; req_lba1 = vecs[v].lba1;
      nxt_rd = vecs[v].nrd; nxt_wr = vecs[v].nwr;
      serve(vecs[v].ack_dly, vecs[v].nstr);
      check_txn($sformatf("vec%0d", v), vecs[v].exp_id, vecs[v].exp_wr, vecs[v].exp_err,
                vecs[v].exp_id ? vecs[v].lba1 : vecs[v].lba0);
    end

    last_m = 0;  // vec11 served drive 0
    for (int r = 0; r < 30; r++) random_round(r);

    // reset asserted mid-transfer aborts without a pulse; drive 0 wins afterwards
    req_rd = 2'b11; req_wr = 2'b00; req_lba0 = 32'h0000_0AAA; req_lba1 = 32'h0000_0BBB;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk_sys);
      if (sd_rd) found = 1'b1;
    end
    check("rst_first_grant_seen", 64'(found), 64'(1));
    sd_ack = 1'b1;
    repeat (2) @(negedge clk_sys);
    sd_buff_wr = 1'b1;
    repeat (100) @(negedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_outputs", 64'({gnt, done, err, busy, sd_rd, sd_wr, sd_lba}), 64'(0));
    sd_buff_wr = 1'b0; sd_ack = 1'b0;
    pulse = 1'b0;
    repeat (3) begin
      @(negedge clk_sys);
      pulse = pulse | (|(done | err));
    end
    check("rst_no_pulse", 64'(pulse), 64'(0));
    reset_n = 1'b1;
    nxt_rd = 2'b00; nxt_wr = 2'b00;
    serve(2, 512);
    check_txn("rst_regrant", 1'b0, 1'b0, 1'b0, 32'h0000_0AAA);

    // watchdog with TIMEOUT_W=4 and no ack
    @(negedge clk_sys);
    t_req_rd = 2'b01; t_req_lba0 = 32'h0000_0777;
    rd_drop = 0; err_at = 0; seen = 1'b0; err_val = 0; done_val = 0;
    for (int i = 1; i <= 40 && err_at == 0; i++) begin
      @(negedge clk_sys);
      if (t_sd_rd) seen = 1'b1;
      else if (seen && rd_drop == 0) rd_drop = i;
      if (t_err != 2'b00) begin err_at = i; err_val = t_err; done_val = t_done; end
    end
    check_range("to_rd_drop_cycles", rd_drop, 15, 17);
    check_range("to_err_cycles", err_at, 15, 17);
    check("to_err_drive", 64'(err_val), 64'(2'b01));
    check("to_no_done", 64'(done_val), 64'(0));
    $display("txn timeout: drive 0 rd dropped at %0d, err at %0d", rd_drop, err_at);

    // late ack holds off the next request until it falls
    t_req_rd = 2'b10; t_req_lba1 = 32'h0000_0999; t_sd_ack = 1'b1;
    pulse = 1'b0;
    repeat (8) begin
      @(negedge clk_sys);
      pulse = pulse | t_sd_rd | t_sd_wr | (|t_gnt);
    end
    check("to_late_ack_blocks", 64'(pulse), 64'(0));
    t_sd_ack = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk_sys);
      if (t_sd_rd) found = 1'b1;
    end
    check("to_regrant_seen", 64'(found), 64'(1));
    check("to_regrant_gnt", 64'(t_gnt), 64'(2'b10));
    check("to_regrant_lba", 64'(t_sd_lba), 64'(32'h0000_0999));
    err_val = 0;
    for (int i = 0; i < 40 && err_val == 0; i++) begin
      @(negedge clk_sys);
      err_val = t_err;
    end
    t_req_rd = 2'b00;
    check("to_second_err", 64'(err_val), 64'(2'b10));
    $display("txn timeout: drive 1 rd err=%b", err_val);
    repeat (3) @(negedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
